// File: rtl/nibble_serializer.sv
// Serializes an N-bit word into N/4 nibbles over a valid/ready stream,
// LSB-first or MSB-first as chosen when the word is accepted.
module nibble_serializer #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] IN_valA,
   input  logic         IN_valid,
   output logic         OUT_ready,
   input  logic         IN_ctrl,
   output logic [3:0]   OUT_nib,
   output logic         OUT_valid,
   input  logic         IN_ready,
   output logic         OUT_last
);

   localparam int NNIB = N / 4;
   localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NNIB - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   word_q, word_d;
   logic           msb_q, msb_d;
   logic [KW-1:0]  k_q, k_d;
   logic [KW-1:0]  nib_idx_s;
   logic           last_s;

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         msb_q   <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         msb_q   <= msb_d;
         k_q     <= k_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      msb_d     = msb_q;
      k_d       = k_q;
      OUT_valid = 1'b0;
      OUT_last  = 1'b0;
      OUT_ready = 1'b0;
      OUT_nib   = 4'd0;
      // MSB-first walks the nibble index downward from the top of the word
      nib_idx_s = msb_q ? (K_LAST - k_q) : k_q;
      last_s    = (k_q == K_LAST);

      case (state_q)
         IDLE: begin
            OUT_ready = 1'b1;
            if (IN_valid) begin
               word_d  = IN_valA;
               msb_d   = IN_ctrl;
               k_d     = '0;
               state_d = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            OUT_valid = 1'b1;
            OUT_nib   = word_q[{nib_idx_s, 2'b00} +: 4];
            OUT_last  = last_s;
            OUT_ready = last_s && IN_ready;
            if (IN_ready) begin
               if (last_s) begin
                  k_d = '0;
                  if (IN_valid) begin
                     word_d  = IN_valA;
                     msb_d   = IN_ctrl;
                     state_d = SEND;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  k_d = k_q + KW'(1);
               end
            end else begin
               state_d = SEND;
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed plus randomized bench for nibble_serializer; expected nibbles come
// from a queue model of the words accepted so far.
module tb_nibble_serializer;

   localparam int N    = 32;
   localparam int NNIB = N / 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] IN_valA;
   logic         IN_valid;
   logic         OUT_ready;
   logic         IN_ctrl;
   logic [3:0]   OUT_nib;
   logic         OUT_valid;
   logic         IN_ready;
   logic         OUT_last;

   int vectors     = 0;
   int miscompares = 0;
   logic [3:0] exp_q[$];

   nibble_serializer #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .IN_valA   (IN_valA),
      .IN_valid  (IN_valid),
      .OUT_ready (OUT_ready),
      .IN_ctrl   (IN_ctrl),
      .OUT_nib   (OUT_nib),
      .OUT_valid (OUT_valid),
      .IN_ready  (IN_ready),
      .OUT_last  (OUT_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Compare all outputs with what the pending-nibble queue implies
   task automatic check_outputs();
      logic       ev, el, er;
      logic [3:0] en;
      ev = (exp_q.size() != 0);
      el = (exp_q.size() == 1);
      er = (exp_q.size() == 0) || ((exp_q.size() == 1) && IN_ready);
      en = ev ? exp_q[0] : 4'd0;
      chk("valid", {3'b000, OUT_valid}, {3'b000, ev});
      chk("nib",   OUT_nib,             en);
      chk("last",  {3'b000, OUT_last},  {3'b000, el});
      chk("ready", {3'b000, OUT_ready}, {3'b000, er});
   endtask

   // Advance the model by one rising edge using the current inputs
   task automatic model_edge();
      logic rdy;
      logic [N-1:0] w;
      if (!rst) begin
         exp_q.delete();
      end else begin
         rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && IN_ready);
         if ((exp_q.size() != 0) && IN_ready) void'(exp_q.pop_front());
         if (rdy && IN_valid) begin
            w = IN_valA;
            for (int i = 0; i < NNIB; i++) begin
               if (IN_ctrl) exp_q.push_back(w[N-4-4*i +: 4]);
               else         exp_q.push_back(w[4*i +: 4]);
            end
         end
      end
   endtask

   task automatic cycle(input logic [N-1:0] w, input logic v, input logic c, input logic r);
      IN_valA  = w;
      IN_valid = v;
      IN_ctrl  = c;
      IN_ready = r;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      logic [N-1:0] rw;
      rst      = 1'b0;
      IN_valA  = '0;
      IN_valid = 1'b0;
      IN_ctrl  = 1'b0;
      IN_ready = 1'b0;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // LSB-first then MSB-first single words, ready held high
      cycle(32'h87654321, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) cycle(32'h0, 1'b0, 1'b0, 1'b1);
      cycle(32'h87654321, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) cycle(32'h0, 1'b0, 1'b0, 1'b1);

      // Back-to-back words with valid held high
      cycle(32'h87654321, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cycle(32'hFEDCBA90, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) cycle(32'h0, 1'b0, 1'b0, 1'b1);

      // Stall for three cycles while nibble 3 is presented
      cycle(32'h87654321, 1'b1, 1'b0, 1'b1);
      cycle(32'h0, 1'b0, 1'b0, 1'b1);
      cycle(32'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cycle(32'h0, 1'b0, 1'b0, 1'b1);

      // Reset after two handshakes must drop valid without a clock edge
      cycle(32'h87654321, 1'b1, 1'b0, 1'b1);
      cycle(32'h0, 1'b0, 1'b0, 1'b1);
      cycle(32'h0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      exp_q.delete();
      check_outputs();
      cycle(32'h0, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      cycle(32'h0000000F, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) cycle(32'h0, 1'b0, 1'b0, 1'b1);

      // Inputs toggling during SEND must not disturb the word in flight
      cycle(32'h13579BDF, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) cycle($urandom, 1'b0, i[0], 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rw = $urandom;
         cycle(rw, ($urandom_range(2, 0) != 0), $urandom_range(1, 0) == 1,
               ($urandom_range(3, 0) != 0));
      end
      for (int i = 0; i < 20; i++) cycle(32'h0, 1'b0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
